hex_display_port: RTL and testbench
===================================

// Module: hex_display_port
// PURPOSE
//  Memory-mapped responder for the six HEX displays, driven by the processor's
//  ADDR/DOUT/W bus; the output-side counterpart of the switch input port.
//  Stores one 8-bit entry per digit (hex nibble or raw segment pattern), decodes
//  it to active-low 7-seg, and supports registered read-back on DIN.
//  Sits beside the LEDR port in main; responds only inside its address window.
// PARAMETERS
//  BASE_HI    4'h2   value of ADDR[15:12] selecting this port (window 0x2000-0x2FFF)
//  BLINK_DIV  25'd12_500_000  Clock cycles per blink phase (used only with HEX_BLINK_EN)
// PORTS
//  Clock   in   1   system clock, all state on rising edge
//  Resetn  in   1   synchronous active-low reset
//  ADDR    in   16  processor address
//  DOUT    in   16  processor write data
//  W       in   1   write strobe, sampled on rising edge
//  DIN     out  16  read-back data, valid one cycle after ADDR presented
//  HEX0..HEX5 out 7 each  active-low segments, bit0=a .. bit6=g
// BEHAVIOUR
//  - Decode: sel = (ADDR[15:12]==BASE_HI); off = ADDR[2:0]. off 0-5 = digit reg,
//    off 6 = CTRL, off 7 = reserved (writes ignored, reads 0x0000).
//  - Write: on edge with W=1 && sel: digit[off] <= DOUT[7:0]; CTRL <= DOUT[5:0]
//    (plus DOUT[8] when HEX_BLINK_EN). DOUT[15:8] otherwise ignored.
//  - Entry format: bit7=1 raw mode, bits[6:0] = segments lit-high (output inverted);
//    bit7=0 hex mode, bits[3:0] decoded 0-F (0x40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E).
//  - CTRL[5:0] = per-digit blank mask; blanked digit drives 7'h7F, stored entry kept.
//  - HEX outputs registered: write at edge N -> HEX changes at edge N+1.
//  - Read: DIN <= sel ? {8'h00, entry} / {7'h00, CTRL} / 0 : 16'h0000, registered on
//    every edge regardless of W. Same-cycle read+write of one offset returns OLD value.
//  - Out-of-window writes: no state change. Bits [11:3] of ADDR not decoded (aliases).
//  - Reset (edge with Resetn=0, wins over W): all entries 8'h80 (raw, all off),
//    CTRL=0, DIN=16'h0000, HEX0..5=7'h7F; reset mid-write discards the write.
// CONFIGURATION
//  HEX_BLINK_EN defined: CTRL[8] = blink enable; prescaler counts 0..BLINK_DIV-1,
//   toggles phase at wrap. Phase=1 && CTRL[8]: all digits show 7'h7F. Clearing CTRL[8]
//   resets counter and phase to 0 on same edge. CTRL read-back includes bit 8.
//  HEX_BLINK_EN undefined: no counter; CTRL[8] writes ignored, reads 0.
// TESTING
//  1 Reset held 2 cycles -> HEX0..5 = 7'h7F, DIN = 16'h0000.
//  2 W=1 ADDR=0x2000 DOUT=0x0005 -> HEX0=7'h12 next edge; read 0x2000 -> DIN=0x0005.
//  3 W=1 ADDR=0x2003 DOUT=0x00FF -> HEX3=7'h00; write 0x2005 DOUT=0x000A -> HEX5=7'h08.
//  4 CTRL 0x2006<-0x0001 -> HEX0=7'h7F, read 0x2000 still 0x0005; CTRL<-0 -> HEX0=7'h12.
//  5 W=1 ADDR=0x1000 / 0x2007 DOUT=0x0003 -> no HEX change; read 0x2007 -> DIN=0x0000;
//    write+read 0x2001 same edge -> DIN shows prior value 0x0080.
//  6 HEX_BLINK_EN, BLINK_DIV=4: CTRL<-0x0100 -> HEX toggle 7'h7F/pattern every 4 cycles;
//    Resetn=0 mid-phase -> HEX=7'h7F, counter 0, CTRL 0.

Source files
------------

// File: rtl/hex_display_port.sv
// Memory-mapped six-digit HEX display port with registered read-back.
// Optional HEX_BLINK_EN adds a CTRL[8] blink enable driven by a prescaler.
module hex_display_port #(
  parameter logic [3:0] BASE_HI = 4'h2
`ifdef HEX_BLINK_EN
  , parameter logic [24:0] BLINK_DIV = 25'd12_500_000
`endif
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  logic [5:0][7:0] digit_q, digit_d;
  logic [5:0][6:0] hex_q, hex_d;
  logic [8:0]      ctrl_q, ctrl_d;
  logic [15:0]     din_q, din_d;
  logic            sel, wr, blink_bit, blank_all;
  logic [2:0]      off;
  logic            unused_bits;

  assign sel = (ADDR[15:12] == BASE_HI);
  assign off = ADDR[2:0];
  assign wr  = W & sel;
  assign unused_bits = ^{ADDR[11:3], DOUT[15:8]};

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Bit 7 selects raw segments (stored lit-high) over hex decode.
  function automatic logic [6:0] entry_seg(input logic [7:0] e);
    return e[7] ? ~e[6:0] : seg7(e[3:0]);
  endfunction

`ifdef HEX_BLINK_EN
  logic [24:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  assign blink_bit = DOUT[8];
  assign blank_all = ctrl_q[8] & phase_q;

  // Counter and phase restart whenever blink is (or becomes) disabled.
  always_comb begin
    cnt_d   = 25'd0;
    phase_d = 1'b0;
    if (ctrl_d[8]) begin
      if (cnt_q == BLINK_DIV - 25'd1) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 25'd1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q   <= 25'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign blink_bit = 1'b0;
  assign blank_all = 1'b0;
`endif

  always_comb begin
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    din_d   = 16'h0000;
    if (wr) begin
      for (int i = 0; i < 6; i++)
        if (off == 3'(i)) digit_d[i] = DOUT[7:0];
      if (off == 3'd6) ctrl_d = {blink_bit, 2'b00, DOUT[5:0]};
    end
    if (sel) begin
      for (int i = 0; i < 6; i++)
        if (off == 3'(i)) din_d = {8'h00, digit_q[i]};
      if (off == 3'd6) din_d = {7'h00, ctrl_q};
    end
    for (int i = 0; i < 6; i++)
      hex_d[i] = (ctrl_q[i] | blank_all) ? 7'h7F : entry_seg(digit_q[i]);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      digit_q <= {6{8'h80}};
      ctrl_q  <= 9'h000;
      din_q   <= 16'h0000;
      hex_q   <= {6{7'h7F}};
    end else begin
      digit_q <= digit_d;
      ctrl_q  <= ctrl_d;
      din_q   <= din_d;
      hex_q   <= hex_d;
    end
  end

  assign DIN  = din_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_port.sv
// Scoreboard bench for hex_display_port; blink test runs with HEX_BLINK_EN.
module tb_hex_display_port;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] ADDR, DOUT, DIN;
  logic        W;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0]     din;
    logic [5:0][6:0] hex;
  } exp_t;

  exp_t sb[$];

  logic [5:0][7:0] m_digit;
  logic [8:0]      m_ctrl;
  logic [6:0]      seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_port #(
    .BASE_HI(4'h2)
`ifdef HEX_BLINK_EN
    , .BLINK_DIV(25'd4)
`endif
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT),
    .W(W), .DIN(DIN),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5));

  always #5 Clock = ~Clock;

  function automatic logic [5:0][6:0] obs_hex();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [6:0] m_hex(int i);
    logic [7:0] e;
    e = m_digit[i];
    if (m_ctrl[i]) return 7'h7F;
    return e[7] ? ~e[6:0] : seg_tab[e[3:0]];
  endfunction

  function automatic logic [15:0] m_read(logic [15:0] a);
    if (a[15:12] != 4'h2) return 16'h0000;
    if (a[2:0] < 3'd6) return {8'h00, m_digit[a[2:0]]};
    if (a[2:0] == 3'd6) return {7'h00, m_ctrl};
    return 16'h0000;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_digit[i] = 8'h80;
    m_ctrl = 9'h000;
  endtask

  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.din = m_read(a);
    for (int i = 0; i < 6; i++) e.hex[i] = m_hex(i);
    sb.push_back(e);
    if (w && a[15:12] == 4'h2) begin
      if (a[2:0] < 3'd6) m_digit[a[2:0]] = d[7:0];
`ifdef HEX_BLINK_EN
      else if (a[2:0] == 3'd6) m_ctrl = {d[8], 2'b00, d[5:0]};
`else
      else if (a[2:0] == 3'd6) m_ctrl = {3'b000, d[5:0]};
`endif
    end
    W = w; ADDR = a; DOUT = d;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    W = 1'b1; ADDR = 16'h2000; DOUT = 16'h0005;
    repeat (2) @(posedge Clock);
    #1;
    m_reset();
    n_checks++;
    if (obs_hex() !== {6{7'h7F}}) begin
      n_fail++;
      $display("FAIL reset_hex got %h want %h", obs_hex(), {6{7'h7F}});
    end
    n_checks++;
    if (DIN !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_din got %h want 0000", DIN);
    end
    Resetn = 1'b1;
    xfer(0, 16'h2000, 16'h0000);
    begin
      exp_t e = sb.pop_front();
      n_checks++;
      if (DIN !== e.din) begin
        n_fail++;
        $display("FAIL reset_entry got %h want %h", DIN, e.din);
      end
    end
  endtask

  task automatic test_hex_write();
    exp_t e;
    xfer(1, 16'h2000, 16'h0005);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL wr_old_din got %h want %h", DIN, e.din);
    end
    xfer(0, 16'h2000, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL rd_digit0 got %h want %h", DIN, e.din);
    end
    n_checks++;
    if (obs_hex() !== e.hex) begin
      n_fail++;
      $display("FAIL hex0_five got %h want %h", obs_hex(), e.hex);
    end
  endtask

  task automatic test_raw_mode();
    exp_t e;
    xfer(1, 16'h2003, 16'h00FF);
    void'(sb.pop_front());
    xfer(1, 16'h2005, 16'h000A);
    void'(sb.pop_front());
    xfer(0, 16'h2003, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL rd_raw got %h want %h", DIN, e.din);
    end
    n_checks++;
    if (obs_hex() !== e.hex) begin
      n_fail++;
      $display("FAIL raw_and_a got %h want %h", obs_hex(), e.hex);
    end
  endtask

  task automatic test_blank_mask();
    exp_t e;
    xfer(1, 16'h2006, 16'h0001);
    void'(sb.pop_front());
    xfer(0, 16'h2000, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL blank_keeps got %h want %h", DIN, e.din);
    end
    xfer(0, 16'h2006, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din || obs_hex() !== e.hex) begin
      n_fail++;
      $display("FAIL blank_on got %h/%h want %h/%h",
               DIN, obs_hex(), e.din, e.hex);
    end
    xfer(1, 16'h2006, 16'h0000);
    void'(sb.pop_front());
    xfer(0, 16'h2000, 16'h0000);
    void'(sb.pop_front());
    xfer(0, 16'h2000, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (obs_hex() !== e.hex) begin
      n_fail++;
      $display("FAIL blank_off got %h want %h", obs_hex(), e.hex);
    end
  endtask

  task automatic test_window();
    exp_t e;
    xfer(1, 16'h1000, 16'h0003);
    void'(sb.pop_front());
    xfer(1, 16'h2007, 16'h0003);
    void'(sb.pop_front());
    xfer(0, 16'h2007, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din || obs_hex() !== e.hex) begin
      n_fail++;
      $display("FAIL out_window got %h/%h want %h/%h",
               DIN, obs_hex(), e.din, e.hex);
    end
    xfer(1, 16'h2001, 16'h0003);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL rw_same_edge got %h want %h", DIN, e.din);
    end
    xfer(1, 16'h2FF9, 16'h0007);
    void'(sb.pop_front());
    xfer(0, 16'h2001, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL alias_wr got %h want %h", DIN, e.din);
    end
  endtask

  task automatic test_ctrl_bits();
    exp_t e;
`ifdef HEX_BLINK_EN
    xfer(1, 16'h2006, 16'hFEFF);
`else
    xfer(1, 16'h2006, 16'hFFFF);
`endif
    void'(sb.pop_front());
    xfer(0, 16'h2006, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL ctrl_rd got %h want %h", DIN, e.din);
    end
    xfer(1, 16'h2006, 16'h0000);
    void'(sb.pop_front());
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] a, d;
    logic [3:0]  hi;
    logic        w;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        a = {4'h2, 9'($urandom), 3'($urandom)};
      end else begin
        hi = 4'($urandom);
        if (hi == 4'h2) hi = 4'h3;
        a = {hi, 12'($urandom)};
      end
      d = 16'($urandom);
`ifdef HEX_BLINK_EN
      d[8] = 1'b0;
`endif
      w = 1'($urandom);
      xfer(w, a, d);
      e = sb.pop_front();
      n_checks++;
      if (DIN !== e.din || obs_hex() !== e.hex) begin
        n_fail++;
        $display("FAIL b2b_%0d got %h/%h want %h/%h",
                 k, DIN, obs_hex(), e.din, e.hex);
      end
    end
  endtask

`ifdef HEX_BLINK_EN
  task automatic blink_run(input int cycles, input string tag);
    exp_t            e;
    logic [5:0][6:0] want;
    for (int k = 1; k <= cycles; k++) begin
      xfer(0, 16'h2000, 16'h0000);
      e = sb.pop_front();
      want = ((k / 4) % 2 == 1) ? {6{7'h7F}} : e.hex;
      n_checks++;
      if (obs_hex() !== want) begin
        n_fail++;
        $display("FAIL %s_k%0d got %h want %h", tag, k, obs_hex(), want);
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    xfer(1, 16'h2000, 16'h0005);
    void'(sb.pop_front());
    xfer(1, 16'h2006, 16'h0100);
    void'(sb.pop_front());
    blink_run(16, "blink");
    Resetn = 1'b0;
    W = 1'b1; ADDR = 16'h2006; DOUT = 16'h0100;
    @(posedge Clock);
    #1;
    m_reset();
    n_checks++;
    if (obs_hex() !== {6{7'h7F}} || DIN !== 16'h0000) begin
      n_fail++;
      $display("FAIL blink_reset got %h/%h", obs_hex(), DIN);
    end
    Resetn = 1'b1;
    xfer(0, 16'h2006, 16'h0000);
    e = sb.pop_front();
    n_checks++;
    if (DIN !== e.din) begin
      n_fail++;
      $display("FAIL blink_ctrl_rst got %h want %h", DIN, e.din);
    end
    xfer(1, 16'h2000, 16'h0005);
    void'(sb.pop_front());
    xfer(1, 16'h2006, 16'h0100);
    void'(sb.pop_front());
    blink_run(9, "reblink");
    xfer(1, 16'h2006, 16'h0000);
    void'(sb.pop_front());
  endtask
`endif

  initial begin
    W = 1'b0; ADDR = 16'h0000; DOUT = 16'h0000; Resetn = 1'b0;
    m_reset();
    @(posedge Clock);
    #1;
    test_reset();
    test_hex_write();
    test_raw_mode();
    test_blank_mask();
    test_window();
    test_ctrl_bits();
    test_back_to_back();
`ifdef HEX_BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
